// File: rtl/piso_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : piso_rr_arbiter
//  Purpose  : Round-robin arbiter sharing one PISO serializer between NREQ
//             parallel-word requesters. The winner's word is captured, offered
//             on the serializer load port, and the frame is tracked through
//             the serializer's busy flag before the next arbitration.
//  Ports    : clk_rx_in, rst (async, active-high)
//             req_valid_i/req_data_i/req_ready_o  - requester side
//             piso_data_o/piso_valid_o/piso_ready_i/piso_busy_i - serializer
//             grant_id_o, frame_done_o, timeout_o - status
//             req_lock_i (only with PISO_ARB_LOCK_EN) - grant hold request
//  Config   : `define PISO_ARB_LOCK_EN enables grant locking (LOCK_MAX).
//  Revision : 1.0 - initial release
// ============================================================================
module piso_rr_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 4,
    parameter int TIMEOUT  = 64,
    parameter int LOCK_MAX = 4
) (
    input  logic                     clk_rx_in,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ*WIDTH-1:0]    req_data_i,
    output logic [NREQ-1:0]          req_ready_o,
    output logic [WIDTH-1:0]         piso_data_o,
    output logic                     piso_valid_o,
    input  logic                     piso_ready_i,
    input  logic                     piso_busy_i,
    output logic [$clog2(NREQ)-1:0]  grant_id_o,
    output logic                     frame_done_o,
`ifdef PISO_ARB_LOCK_EN
    input  logic [NREQ-1:0]          req_lock_i,
`endif
    output logic                     timeout_o
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CW-1:0]      tcnt_q, tcnt_d;
    logic [NREQ-1:0]    ready_q, ready_d;
    logic               done_q, done_d;
    logic               tmo_q, tmo_d;

`ifdef PISO_ARB_LOCK_EN
    localparam int LCW = $clog2(LOCK_MAX) + 1;
    logic [LCW-1:0]     lock_cnt_q, lock_cnt_d;
`endif

    // Round-robin search: walk the request vector starting at ptr_q and
    // wrapping with an explicit compare, so NREQ need not be a power of two.
    logic               win_found;
    logic [IDW-1:0]     win_idx;
    logic [IDW-1:0]     scan_idx;
    logic [WIDTH-1:0]   win_data;
    logic [IDW-1:0]     grant_next;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req_valid_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
            scan_idx = (scan_idx == IDW'(NREQ - 1)) ? '0 : scan_idx + IDW'(1);
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                win_data = req_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign grant_next = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        tcnt_d  = tcnt_q;
        ready_d = '0;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
`ifdef PISO_ARB_LOCK_EN
        lock_cnt_d = lock_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d          = ST_LOAD;
                    grant_d          = win_idx;
                    data_d           = win_data;
                    ready_d[win_idx] = 1'b1;
`ifdef PISO_ARB_LOCK_EN
                    // A lock holder that was not valid lost its streak.
                    if (win_idx != ptr_q) begin
                        lock_cnt_d = '0;
                    end
`endif
                end
            end
            ST_LOAD: begin
                if (piso_ready_i) begin
                    state_d = ST_WAIT;
                    tcnt_d  = '0;
                end
            end
            ST_WAIT: begin
                if (piso_busy_i) begin
                    state_d = ST_DRAIN;
                end else if (tcnt_q == CW'(TIMEOUT - 1)) begin
                    // Serializer never started: abandon the frame but still
                    // move priority on so a stuck requester cannot hog it.
                    state_d = ST_IDLE;
                    tmo_d   = 1'b1;
                    ptr_d   = grant_next;
`ifdef PISO_ARB_LOCK_EN
                    lock_cnt_d = '0;
`endif
                end else begin
                    tcnt_d = tcnt_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (!piso_busy_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`ifdef PISO_ARB_LOCK_EN
                    // lock_cnt counts repeat grants, so the holder owns at
                    // most LOCK_MAX consecutive frames in total.
                    if (req_lock_i[grant_q] && (lock_cnt_q < LCW'(LOCK_MAX - 1))) begin
                        ptr_d      = grant_q;
                        lock_cnt_d = lock_cnt_q + LCW'(1);
                    end else begin
                        ptr_d      = grant_next;
                        lock_cnt_d = '0;
                    end
`else
                    ptr_d = grant_next;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_rx_in or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            tcnt_q  <= '0;
            ready_q <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
`ifdef PISO_ARB_LOCK_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            tcnt_q  <= tcnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
`ifdef PISO_ARB_LOCK_EN
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    assign req_ready_o  = ready_q;
    assign piso_data_o  = data_q;
    assign piso_valid_o = (state_q == ST_LOAD);
    assign grant_id_o   = grant_q;
    assign frame_done_o = done_q;
    assign timeout_o    = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_rr_arbiter
//  Purpose  : Self-checking bench for piso_rr_arbiter (default build, no lock).
//             Directed frames plus randomized traffic against a round-robin
//             reference model and a cycle-exact serializer model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_piso_rr_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 64;

    logic                    clk_rx_in = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_valid_i;
    logic [NREQ*WIDTH-1:0]   req_data_i;
    logic [NREQ-1:0]         req_ready_o;
    logic [WIDTH-1:0]        piso_data_o;
    logic                    piso_valid_o;
    logic                    piso_ready_i;
    logic                    piso_busy_i;
    logic [1:0]              grant_id_o;
    logic                    frame_done_o;
    logic                    timeout_o;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;   // reference priority pointer

    piso_rr_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .TIMEOUT  (TIMEOUT),
        .LOCK_MAX (4)
    ) u_dut (
        .clk_rx_in    (clk_rx_in),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .piso_data_o  (piso_data_o),
        .piso_valid_o (piso_valid_o),
        .piso_ready_i (piso_ready_i),
        .piso_busy_i  (piso_busy_i),
        .grant_id_o   (grant_id_o),
        .frame_done_o (frame_done_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_rx_in = ~clk_rx_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_rx_in);
        #1;
    endtask

    // First valid requester at or after p, modulo NREQ.
    function automatic int pick(input int p, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (p + k) % NREQ;
            if (v[j]) return j;
        end
        return 0;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, req_ready_o, 0);
        check({tag, "_pvalid"}, piso_valid_o, 0);
        check({tag, "_pdata"}, piso_data_o, 0);
        check({tag, "_grant"}, grant_id_o, 0);
        check({tag, "_done"}, frame_done_o, 0);
        check({tag, "_tmo"}, timeout_o, 0);
    endtask

    // One frame from the IDLE sample point. busy rises d cycles after the
    // accept edge (d = -1: already high during accept) and stays high len
    // cycles; tmo = serializer never goes busy.
    task automatic run_frame(input logic [NREQ-1:0] vld, input logic [NREQ*WIDTH-1:0] dat,
                             input int stall, input int d, input int len, input bit tmo);
        int win;
        int n;
        logic [WIDTH-1:0] w;
        win = pick(ptr_m, vld);
        w   = dat[win*WIDTH +: WIDTH];
        req_valid_i  = vld;
        req_data_i   = dat;
        piso_ready_i = 1'b0;
        piso_busy_i  = 1'b0;
        tick();
        check("ready_pulse", req_ready_o, 32'(1) << win);
        check("grant_id", grant_id_o, win);
        check("load_valid", piso_valid_o, 1);
        check("load_data", piso_data_o, w);
        check("done_pulse_width", frame_done_o, 0);
        // Requester withdraws and its bus changes: the held word must not.
        req_valid_i[win] = 1'b0;
        req_data_i       = (NREQ*WIDTH)'($urandom);
        repeat (stall) begin
            tick();
            check("stall_valid", piso_valid_o, 1);
            check("stall_data", piso_data_o, w);
            check("stall_no_ready", req_ready_o, 0);
        end
        piso_ready_i = 1'b1;
        piso_busy_i  = (d < 0);
        tick();
        piso_ready_i = 1'b0;
        check("accept_drop_valid", piso_valid_o, 0);
        check("no_ready_after_load", req_ready_o, 0);
        n = 0;
        if (tmo) begin
            piso_busy_i = 1'b0;
            while (timeout_o !== 1'b1 && n < 4 * TIMEOUT) begin
                tick();
                n++;
                check("wait_no_ready", req_ready_o, 0);
            end
            check("timeout_latency", n, TIMEOUT);
            check("timeout_no_done", frame_done_o, 0);
        end else begin
            piso_busy_i = (0 >= d) && (0 < d + len);
            while (n < d + len + 1) begin
                tick();
                n++;
                check("done_timing", frame_done_o, (n == d + len + 1));
                check("no_timeout", timeout_o, 0);
                piso_busy_i = (n >= d) && (n < d + len);
            end
        end
        piso_busy_i = 1'b0;
        ptr_m = (win + 1) % NREQ;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        req_valid_i  = '0;
        req_data_i   = '0;
        piso_ready_i = 1'b0;
        piso_busy_i  = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("post_reset_idle");

        // Round-robin over all four requesters: A,B,C,D,A.
        for (int f = 0; f < 5; f++) begin
            run_frame(4'hF, 16'hDCBA, 0, 0, 4, 1'b0);
        end

        // Backpressure: serializer refuses the load for 5 cycles.
        run_frame(4'b0010, 16'h5A3C, 5, 1, 3, 1'b0);

        // Sparse wrap from pointer 2: requester 3, then requester 1.
        run_frame(4'b1010, 16'h7E96, 0, 0, 2, 1'b0);
        run_frame(4'b0010, 16'h7E96, 1, 2, 3, 1'b0);

        // Ready and busy together in the accept cycle.
        run_frame(4'b0001, 16'h1234, 0, -1, 3, 1'b0);

        // Timeout, then priority moves to grant+1.
        run_frame(4'hF, 16'h4321, 0, 0, 0, 1'b1);
        run_frame(4'hF, 16'h8765, 0, 0, 2, 1'b0);

        // Reset in the middle of LOAD, then requester 2 alone.
        req_valid_i = 4'b0001;
        req_data_i  = 16'h0009;
        tick();
        check("pre_rst_load", piso_valid_o, 1);
        rst = 1'b1;
        #1;
        check_all_zero("mid_load_reset");
        tick();
        rst         = 1'b0;
        req_valid_i = '0;
        ptr_m       = 0;
        run_frame(4'b0100, 16'h0B00, 0, 0, 2, 1'b0);

        // Randomized traffic.
        for (int f = 0; f < 40; f++) begin
            logic [NREQ-1:0] v;
            if ($urandom_range(0, 3) == 0) begin
                req_valid_i = '0;
                tick();
                check("idle_no_ready", req_ready_o, 0);
                check("idle_no_load", piso_valid_o, 0);
            end
            v = NREQ'($urandom_range(1, 15));
            run_frame(v, (NREQ*WIDTH)'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)) - 1, int'($urandom_range(2, 6)),
                      ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
